serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/two's-complement subtractor: one full-subtractor step per
// clock, LSB first, with borrow-out and signed-overflow flags latched at the end.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] dSr_q, dSr_d;
  logic             bin_q, bin_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic bitDiff;
  logic bitBout;

  assign bitDiff = aSr_q[0] ^ bSr_q[0] ^ bin_q;
  assign bitBout = (~aSr_q[0] & bSr_q[0]) | (~(aSr_q[0] ^ bSr_q[0]) & bin_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aSr_d    = aSr_q;
    bSr_d    = bSr_q;
    dSr_d    = dSr_q;
    bin_d    = bin_q;
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          aSr_d   = a;
          bSr_d   = b;
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
          dSr_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Once all bits are in, spend one more SHIFT cycle publishing the result.
        if (cnt_q == LAST_BIT) begin
          diff_d   = dSr_q;
          borrow_d = bin_q;
          ovf_d    = (aMsb_q != bMsb_q) && (dSr_q[WIDTH-1] != aMsb_q);
          state_d  = DONE;
        end else begin
          aSr_d = aSr_q >> 1;
          bSr_d = bSr_q >> 1;
          dSr_d = {bitDiff, dSr_q[WIDTH-1:1]};
          bin_d = bitBout;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      aSr_q    <= '0;
      bSr_q    <= '0;
      dSr_q    <= '0;
      bin_q    <= 1'b0;
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aSr_q    <= aSr_d;
      bSr_q    <= bSr_d;
      dSr_q    <= dSr_d;
      bin_q    <= bin_d;
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): expected results are queued
// at launch and popped when done is seen.
module tb_serial_subtractor;

  localparam int WIDTH   = 4;
  localparam int LATENCY = WIDTH + 1;
  localparam int MAXWAIT = 20;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } expT;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  int  assertCount = 0;
  int  failCount   = 0;
  expT sbQ[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic expT refModel(input int av, input int bv);
    expT r;
    int  sa, sb, sd;
    sa = (av >= 8) ? av - 16 : av;
    sb = (bv >= 8) ? bv - 16 : bv;
    sd = sa - sb;
    r.diff   = 4'((av - bv) & 15);
    r.borrow = (av < bv);
    r.ovf    = (sd > 7) || (sd < -8);
    return r;
  endfunction

  // Pulses start for one cycle, then scrambles the operands to prove they were latched.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    sbQ.push_back(refModel(int'(av), int'(bv)));
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom_range(0, 15));
    b     = 4'($urandom_range(0, 15));
  endtask

  task automatic waitDone(output int cycles, output bit timedOut);
    cycles = 0;
    while (done !== 1'b1 && cycles < MAXWAIT) begin
      @(negedge clk);
      cycles++;
    end
    timedOut = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done got %b want 0", done); end
    assertCount++; if (diff !== 4'd0) begin failCount++; $display("[TB] FAIL reset_diff got %0d want 0", diff); end
    assertCount++; if (borrow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_borrow got %b want 0", borrow); end
    assertCount++; if (ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] va[3];
    logic [WIDTH-1:0] vb[3];
    int  cyc;
    bit  to;
    expT e;
    va[0] = 4'd9; vb[0] = 4'd3;
    va[1] = 4'd3; vb[1] = 4'd9;
    va[2] = 4'd7; vb[2] = 4'd8;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(va[i], vb[i]);
      assertCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL basic%0d_busy got %b want 1", i, busy); end
      waitDone(cyc, to);
      e = sbQ.pop_front();
      assertCount++; if (to || cyc != LATENCY) begin failCount++; $display("[TB] FAIL basic%0d_latency got %0d want %0d", i, cyc, LATENCY); end
      assertCount++; if (diff !== e.diff) begin failCount++; $display("[TB] FAIL basic%0d_diff got %0d want %0d", i, diff, e.diff); end
      assertCount++; if (borrow !== e.borrow) begin failCount++; $display("[TB] FAIL basic%0d_borrow got %b want %b", i, borrow, e.borrow); end
      assertCount++; if (ovf !== e.ovf) begin failCount++; $display("[TB] FAIL basic%0d_ovf got %b want %b", i, ovf, e.ovf); end
      @(negedge clk);
      assertCount++; if (done !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic%0d_after_done got done=%b busy=%b want 0 0", i, done, busy); end
      repeat (2) @(negedge clk);
      assertCount++; if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf) begin
        failCount++; $display("[TB] FAIL basic%0d_hold got %0d/%b/%b want %0d/%b/%b", i, diff, borrow, ovf, e.diff, e.borrow, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  cyc, gap, idleCnt, unstable;
    bit  to;
    expT e;
    @(negedge clk);
    a     = 4'd5;
    b     = 4'd5;
    start = 1'b1;
    sbQ.push_back(refModel(5, 5));
    @(negedge clk);
    a = 4'd10;
    b = 4'd3;
    waitDone(cyc, to);
    e = sbQ.pop_front();
    assertCount++; if (to || cyc != LATENCY) begin failCount++; $display("[TB] FAIL b2b_first_latency got %0d want %0d", cyc, LATENCY); end
    assertCount++; if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf) begin
      failCount++; $display("[TB] FAIL b2b_first_result got %0d/%b/%b want %0d/%b/%b", diff, borrow, ovf, e.diff, e.borrow, e.ovf);
    end
    // Start stays high: ignored in DONE, accepted on the following IDLE edge with a=10, b=3.
    sbQ.push_back(refModel(10, 3));
    gap = 0; idleCnt = 0; unstable = 0;
    do begin
      @(negedge clk);
      gap++;
      if (busy === 1'b0) idleCnt++;
      if (done !== 1'b1 && diff !== e.diff) unstable++;
    end while (done !== 1'b1 && gap < MAXWAIT);
    start = 1'b0;
    assertCount++; if (gap != LATENCY + 2) begin failCount++; $display("[TB] FAIL b2b_gap got %0d want %0d", gap, LATENCY + 2); end
    assertCount++; if (idleCnt != 1) begin failCount++; $display("[TB] FAIL b2b_idle_cycles got %0d want 1", idleCnt); end
    assertCount++; if (unstable != 0) begin failCount++; $display("[TB] FAIL b2b_stable got %0d changes want 0", unstable); end
    e = sbQ.pop_front();
    assertCount++; if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf) begin
      failCount++; $display("[TB] FAIL b2b_second_result got %0d/%b/%b want %0d/%b/%b", diff, borrow, ovf, e.diff, e.borrow, e.ovf);
    end
    repeat (2) @(negedge clk);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_no_third_op got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int  cyc, doneSeen;
    bit  to;
    expT e;
    applyStimulus(4'd12, 4'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
    assertCount++; if (busy !== 1'b0 || done !== 1'b0) begin failCount++; $display("[TB] FAIL abort_ctrl got busy=%b done=%b want 0 0", busy, done); end
    assertCount++; if (diff !== 4'd0 || borrow !== 1'b0 || ovf !== 1'b0) begin
      failCount++; $display("[TB] FAIL abort_outputs got %0d/%b/%b want 0/0/0", diff, borrow, ovf);
    end
    doneSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0) doneSeen++;
    end
    assertCount++; if (doneSeen != 0) begin failCount++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", doneSeen); end
    applyStimulus(4'd12, 4'd1);
    waitDone(cyc, to);
    e = sbQ.pop_front();
    assertCount++; if (to || cyc != LATENCY) begin failCount++; $display("[TB] FAIL abort_fresh_latency got %0d want %0d", cyc, LATENCY); end
    assertCount++; if (diff !== e.diff || borrow !== e.borrow || ovf !== e.ovf) begin
      failCount++; $display("[TB] FAIL abort_fresh_result got %0d/%b/%b want %0d/%b/%b", diff, borrow, ovf, e.diff, e.borrow, e.ovf);
    end
  endtask

  task automatic test_exhaustive();
    int  cyc;
    bit  to;
    expT e;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        applyStimulus(4'(ai), 4'(bi));
        waitDone(cyc, to);
        e = sbQ.pop_front();
        assertCount++; if (to) begin failCount++; $display("[TB] FAIL sweep_timeout a=%0d b=%0d got no done want done", ai, bi); end
        assertCount++; if (diff !== e.diff) begin failCount++; $display("[TB] FAIL sweep_diff a=%0d b=%0d got %0d want %0d", ai, bi, diff, e.diff); end
        assertCount++; if (borrow !== e.borrow) begin failCount++; $display("[TB] FAIL sweep_borrow a=%0d b=%0d got %b want %b", ai, bi, borrow, e.borrow); end
        assertCount++; if (ovf !== e.ovf) begin failCount++; $display("[TB] FAIL sweep_ovf a=%0d b=%0d got %b want %b", ai, bi, ovf, e.ovf); end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
